// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: flag bit positions, operation codes,
// default widths and the result-queue occupancy encoding.
package alu_pkg;

  localparam int FLAG_Z  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_V  = 2;
  localparam int FLAG_DZ = 3;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MUL = 1'b1;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_RD_W   = 3;

  // Queue occupancy; the encoding equals the entry count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } qstate_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry FIFO with a dedicated head register so the output is always
// a flop. A push into an empty queue lands in the head; a push while one
// entry is held lands in the tail unless the head pops in the same cycle.
module result_fifo2
  import alu_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  qstate_e        state_q, state_d;
  logic [W-1:0]   head_q, head_d;
  logic [W-1:0]   tail_q, tail_d;
  logic           do_push, do_pop;

  // Next-state: occupancy transitions and entry movement between head and tail.
  always_comb begin
    do_push = push & (state_q != Q_FULL);
    do_pop  = pop & (state_q != Q_EMPTY);
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      Q_EMPTY: begin
        if (do_push) begin
          head_d  = push_data;
          state_d = Q_ONE;
        end
      end
      Q_ONE: begin
        case ({do_push, do_pop})
          2'b10: begin
            tail_d  = push_data;
            state_d = Q_FULL;
          end
          2'b01: state_d = Q_EMPTY;
          2'b11: head_d  = push_data;
          default: ;
        endcase
      end
      Q_FULL: begin
        if (do_pop) begin
          head_d  = tail_q;
          state_d = Q_ONE;
        end
      end
      default: state_d = Q_EMPTY;
    endcase
  end

  // State and storage registers; reset empties the queue and clears the entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= Q_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head  = head_q;
  assign count = state_q;
  assign full  = (state_q == Q_FULL);
  assign empty = (state_q == Q_EMPTY);

endmodule

// File: rtl/alu_result_stage.sv
// Stage behind the ALU: queues results for register writeback, drops
// writes to the hard-wired zero register, holds the architectural flags
// that feed back into the ALU and counts overflow events for debug.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int L    = ALU_DATA_W,
  parameter int RD_W = ALU_RD_W
) (
  input  logic                Clock,
  input  logic                ResetN,
  input  logic                InValid,
  output logic                InReady,
  input  logic signed [L-1:0] InR,
  input  logic [L-1:0]        InFlags,
  input  logic [RD_W-1:0]     InRd,
  input  logic                InWriteFlags,
  output logic [L-1:0]        FlagsReg,
  output logic                OutValid,
  input  logic                OutReady,
  output logic signed [L-1:0] OutData,
  output logic [RD_W-1:0]     OutRd,
  output logic [1:0]          Count,
  output logic [7:0]          OvfCount
);

  localparam int W = L + RD_W;

  logic           accept, push, pop;
  logic           q_full, q_empty;
  logic [W-1:0]   head;
  logic [L-1:0]   flags_q, flags_d;
  logic [7:0]     ovf_cnt_q, ovf_cnt_d;

  // InReady looks only at registered occupancy, never at OutReady.
  assign InReady  = ResetN & ~q_full;
  assign accept   = InValid & InReady;
  assign push     = accept & (InRd != '0);
  assign OutValid = ~q_empty;
  assign pop      = OutValid & OutReady & ResetN;

  result_fifo2 #(
    .W(W)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (ResetN),
    .push      (push),
    .push_data ({InR, InRd}),
    .pop       (pop),
    .head      (head),
    .count     (Count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign OutData = head[W-1:RD_W];
  assign OutRd   = head[RD_W-1:0];

  // Flags update and saturating overflow count, both only on a flag-writing accept.
  always_comb begin
    flags_d   = flags_q;
    ovf_cnt_d = ovf_cnt_q;
    if (accept && InWriteFlags) begin
      flags_d = InFlags;
      if (InFlags[FLAG_V] && (ovf_cnt_q != 8'hFF)) begin
        ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
    end
  end

  // Architectural flags and debug counter registers.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      flags_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      flags_q   <= flags_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign FlagsReg = flags_q;
  assign OvfCount = ovf_cnt_q;

endmodule
